// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: serial line in, framed word and status out.
// master = the receiver, slave = whatever drives the line and consumes the words.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 rx_busy;

   modport master (input rx, output rx_data, output rx_valid, output frame_err, output rx_busy);
   modport slave  (output rx, input rx_data, input rx_valid, input frame_err, input rx_busy);
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, free-running sample tick,
// mid-bit start validation, LSB-first shift-in, stop-bit check with break recovery.
module uart_rx #(
   parameter int FRE        = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.master bus
);
   localparam int DIV = FRE / (BAUD_RATE * OVERSAMPLE);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int NW  = $clog2(DATA_BITS);

   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   logic                 r_sync1, r_sync2;
   logic [TW-1:0]        r_tick_cnt;
   state_t               r_state, w_state_next;
   logic [SW-1:0]        r_s, w_s_next;
   logic [NW-1:0]        r_n, w_n_next;
   logic [DATA_BITS-1:0] r_shift, w_shift_next;
   logic [DATA_BITS-1:0] r_data, w_data_next;
   logic                 r_valid, w_valid_next;
   logic                 r_ferr, w_ferr_next;
   logic                 w_tick;
   logic                 w_rxs;

   assign w_rxs  = r_sync2;
   assign w_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_tick_cnt <= '0;
      end else begin
         r_sync1    <= bus.rx;
         r_sync2    <= r_sync1;
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_s     <= w_s_next;
         r_n     <= w_n_next;
         r_shift <= w_shift_next;
         r_data  <= w_data_next;
         r_valid <= w_valid_next;
         r_ferr  <= w_ferr_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_s_next     = r_s;
      w_n_next     = r_n;
      w_shift_next = r_shift;
      w_data_next  = r_data;
      w_valid_next = 1'b0;
      w_ferr_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_tick && !w_rxs) begin
               w_state_next = START;
               w_s_next     = '0;
            end
         end
         START: begin
            if (w_tick) begin
               if (r_s == S_MID) begin
                  // A start bit that has gone high again by mid-bit is a glitch.
                  w_state_next = w_rxs ? IDLE : DATA;
                  w_s_next     = '0;
                  w_n_next     = '0;
               end else begin
                  w_s_next = r_s + SW'(1);
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_s == S_LAST) begin
                  w_shift_next = {w_rxs, r_shift[DATA_BITS-1:1]};
                  w_s_next     = '0;
                  if (r_n == N_LAST) w_state_next = STOP;
                  else               w_n_next     = r_n + NW'(1);
               end else begin
                  w_s_next = r_s + SW'(1);
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_s == S_LAST) begin
                  w_s_next = '0;
                  if (w_rxs) begin
                     w_data_next  = r_shift;
                     w_valid_next = 1'b1;
                     w_state_next = IDLE;
                  end else begin
                     w_ferr_next  = 1'b1;
                     w_state_next = BRK;
                  end
               end else begin
                  w_s_next = r_s + SW'(1);
               end
            end
         end
         BRK: begin
            // Hold off start detection until the line has returned high.
            if (w_tick && w_rxs) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign bus.rx_data   = r_data;
   assign bus.rx_valid  = r_valid;
   assign bus.frame_err = r_ferr;
   assign bus.rx_busy   = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: a fast instance (1 tick per clock) for framing cases
// and a default-parameter instance for the real baud divider.
module tb_uart_rx;
   localparam int BIT_CLK   = 16;
   localparam int DIV_DEF   = 50_000_000 / (9600 * 16);
   localparam int BIT_CLK_2 = 50_000_000 / 9600;

   typedef struct {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   int   vtimes[$];
   logic [7:0] exp_last = 8'h00;

   uart_rx_if #(.DATA_BITS(8)) bus ();
   uart_rx_if #(.DATA_BITS(8)) bus2 ();

   uart_rx #(.FRE(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_BITS(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   uart_rx u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bit_out(input logic v, input int n);
      bus.rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stopb);
      bit_out(1'b0, BIT_CLK);
      for (int i = 0; i < 8; i++) bit_out(d[i], BIT_CLK);
      bit_out(stopb, BIT_CLK);
   endtask

   task automatic push_data(input logic [7:0] d);
      exp_t e;
      e.err = 1'b0;
      e.data = d;
      sb.push_back(e);
      exp_last = d;
   endtask

   // Scoreboard monitor for the fast instance
   always @(negedge clk) begin
      exp_t e;
      if (bus.rx_valid || bus.frame_err) begin
         chk("valid_ferr_exclusive", 32'(bus.rx_valid & bus.frame_err), 0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'({bus.frame_err, bus.rx_valid}), 0);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind_ferr", 32'(bus.frame_err), 32'(e.err));
            chk("rx_data", 32'(bus.rx_data), 32'(e.data));
            if (bus.rx_valid) vtimes.push_back(cyc);
            $display("[TB] cycle %0d: %s rx_data=0x%02h", cyc,
                     bus.rx_valid ? "rx_valid " : "frame_err", bus.rx_data);
         end
      end
   end

   initial begin
      int cnt;
      int busy_cnt;
      int t_a;
      int k;
      logic seen;
      logic [7:0] got2;
      int ferr2;

      bus.rx  = 1'b1;
      bus2.rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rx_data", 32'(bus.rx_data), 0);
      chk("reset_rx_valid", 32'(bus.rx_valid), 0);
      chk("reset_frame_err", 32'(bus.frame_err), 0);
      chk("reset_rx_busy", 32'(bus.rx_busy), 0);
      rst = 1'b0;
      bit_out(1'b1, 20);

      // 1: single frame and its latency
      push_data(8'hA5);
      cnt = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            do begin
               @(posedge clk);
               #1;
               cnt++;
            end while (!bus.rx_valid && cnt < 400);
         end
      join
      chk("t1_latency_in_window", 32'(cnt >= 153 && cnt <= 155), 1);
      chk("t1_rx_data", 32'(bus.rx_data), 32'hA5);
      bit_out(1'b1, 20);

      // 2: back-to-back frames, no idle gap
      vtimes.delete();
      push_data(8'h00);
      push_data(8'hFF);
      push_data(8'h3C);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      bit_out(1'b1, 40);
      chk("t2_valid_count", vtimes.size(), 3);
      if (vtimes.size() == 3) begin
         chk("t2_gap_1", vtimes[1] - vtimes[0], 160);
         chk("t2_gap_2", vtimes[2] - vtimes[1], 160);
      end

      // 3: start glitch
      busy_cnt = 0;
      fork
         begin
            bit_out(1'b0, 4);
            bit_out(1'b1, 30);
         end
         begin
            repeat (34) begin
               @(posedge clk);
               #1;
               if (bus.rx_busy) busy_cnt++;
            end
         end
      join
      chk("t3_busy_brief", 32'(busy_cnt > 0 && busy_cnt < 12), 1);
      chk("t3_back_idle", 32'(bus.rx_busy), 0);
      push_data(8'h5A);
      send_frame(8'h5A, 1'b1);
      bit_out(1'b1, 20);

      // 4: framing error followed by a break, then recovery
      begin
         exp_t e;
         e.err = 1'b1;
         e.data = exp_last;
         sb.push_back(e);
      end
      send_frame(8'h81, 1'b0);
      bit_out(1'b0, 100);
      bit_out(1'b1, 32);
      push_data(8'h42);
      send_frame(8'h42, 1'b1);
      bit_out(1'b1, 20);

      // 5: reset during data bits of 0xFD; the remaining bits are all high
      bit_out(1'b0, BIT_CLK);
      bit_out(1'b1, BIT_CLK);
      bit_out(1'b0, BIT_CLK);
      bit_out(1'b1, BIT_CLK);
      rst = 1'b1;
      bus.rx = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t5_rst_rx_data", 32'(bus.rx_data), 0);
      chk("t5_rst_rx_valid", 32'(bus.rx_valid), 0);
      chk("t5_rst_frame_err", 32'(bus.frame_err), 0);
      chk("t5_rst_rx_busy", 32'(bus.rx_busy), 0);
      exp_last = 8'h00;
      bit_out(1'b1, BIT_CLK - 1 + 5 * BIT_CLK);
      push_data(8'h99);
      send_frame(8'h99, 1'b1);
      bit_out(1'b1, 20);
      chk("sb_drained", sb.size(), 0);

      // 6: default parameters, tick period and a 9600-baud frame
      k = 0;
      while (!u_dut2.w_tick && k < 1000) begin
         @(posedge clk);
         #1;
         k++;
      end
      t_a = cyc;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!u_dut2.w_tick && k < 1000);
      chk("t6_tick_period", cyc - t_a, DIV_DEF);

      seen  = 1'b0;
      got2  = 8'h00;
      ferr2 = 0;
      fork
         begin
            logic [9:0] fr;
            fr = {1'b1, 8'h55, 1'b0};
            for (int i = 0; i < 10; i++) begin
               bus2.rx = fr[i];
               repeat (BIT_CLK_2) @(posedge clk);
               #1;
            end
         end
         begin
            k = 0;
            while (!seen && k < 60000) begin
               @(posedge clk);
               #1;
               k++;
               if (bus2.frame_err) ferr2++;
               if (bus2.rx_valid) begin
                  seen = 1'b1;
                  got2 = bus2.rx_data;
               end
            end
         end
      join
      chk("t6_valid_seen", 32'(seen), 1);
      chk("t6_rx_data", 32'(got2), 32'h55);
      chk("t6_no_frame_err", ferr2, 0);
      if (seen) $display("[TB] default-rate rx_valid rx_data=0x%02h", got2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
